// File: rtl/top.sv
// UART-to-SD bridge: bytes from a UART RX are queued in a 512-byte FIFO and written to an
// SD card in SPI mode as 512-byte blocks after the card has been initialised.
//
// state       | meaning
// PWRUP       | CS high, 80 clocks with MOSI high
// CMD_FF      | CS low, one 0xFF lead byte
// CMD_TX      | 6 command frame bytes
// CMD_RESP    | poll for R1 (bit7 = 0), up to 8 bytes
// CMD_TRAIL   | read and drop the 4 trailing R7 bytes of CMD8
// CMD_END     | CS high, 8 dummy clocks, then pick the next command or state
// READY       | idle, waiting for a full FIFO or an idle UART line
// WR_GAP      | 0xFF gap before the data token
// WR_TOKEN    | start-block token 0xFE
// WR_DATA     | 512 data bytes popped from the FIFO, zero padded
// WR_CRC      | two dummy CRC bytes
// WR_RESP     | data response byte
// WR_BUSY     | clock 0xFF until the card releases busy
module top #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BAUD        = 9600,
  parameter int IDLE_BITS   = 10,
  parameter int INIT_CK_DIV = 128
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mosi,
  output logic sd_ck,
  output logic sd_mosi,
  input  logic sd_miso,
  output logic sd_csn
);

  localparam int BIT_CLKS  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HALF_CLKS = BIT_CLKS / 2;
  localparam int IDLE_CLKS = IDLE_BITS * BIT_CLKS;
  localparam int BTW       = $clog2(BIT_CLKS + 1);
  localparam int ITW       = $clog2(IDLE_CLKS + 1);
  localparam int HW        = $clog2(INIT_CK_DIV);

  typedef enum logic [3:0] {
    S_PWRUP, S_CMD_FF, S_CMD_TX, S_CMD_RESP, S_CMD_TRAIL, S_CMD_END, S_READY,
    S_WR_GAP, S_WR_TOKEN, S_WR_DATA, S_WR_CRC, S_WR_RESP, S_WR_BUSY
  } state_e;

  typedef enum logic [2:0] {C_CMD0, C_CMD8, C_CMD55, C_ACMD41, C_CMD24} cmd_e;

  // ---------------- UART receiver ----------------
  logic           rx_s1, rx_s2, rx_prev, rx_act, rx_wr;
  logic [BTW-1:0] rx_tmr;
  logic [3:0]     rx_bit;
  logic [7:0]     rx_sr;
  logic [ITW-1:0] idle_tmr;
  logic           idle_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_act   <= 1'b0;
      rx_wr    <= 1'b0;
      rx_tmr   <= '0;
      rx_bit   <= '0;
      rx_sr    <= '0;
      idle_tmr <= '0;
    end else begin
      rx_s1   <= mosi;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_wr   <= 1'b0;
      if (!rx_act) begin
        if (rx_prev && !rx_s2) begin
          rx_act <= 1'b1;
          rx_bit <= '0;
          rx_tmr <= BTW'(HALF_CLKS - 1);
        end else if (idle_tmr != '0) begin
          idle_tmr <= idle_tmr - 1'b1;
        end
      end else if (rx_tmr != '0) begin
        rx_tmr <= rx_tmr - 1'b1;
      end else begin
        rx_tmr <= BTW'(BIT_CLKS - 1);
        rx_bit <= rx_bit + 4'd1;
        if (rx_bit == 4'd0) begin
          if (rx_s2) rx_act <= 1'b0;        // start glitch, not a real start bit
        end else if (rx_bit != 4'd9) begin
          rx_sr <= {rx_s2, rx_sr[7:1]};
        end else begin
          rx_act   <= 1'b0;
          rx_wr    <= rx_s2;
          idle_tmr <= ITW'(IDLE_CLKS);
        end
      end
    end
  end

  assign idle_done = !rx_act && (idle_tmr == '0);

  // ---------------- FIFO ----------------
  logic [7:0] fifo_mem [512];
  logic [8:0] wr_ptr, rd_ptr;
  logic [9:0] fifo_cnt;
  logic       fifo_wr, fifo_rd, fifo_empty;
  logic [7:0] fifo_dout;

  assign fifo_wr    = rx_wr && (fifo_cnt != 10'd512);
  assign fifo_empty = (fifo_cnt == 10'd0);
  assign fifo_dout  = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= rx_sr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 9'd1;
      if (fifo_rd) rd_ptr <= rd_ptr + 9'd1;
      case ({fifo_wr, fifo_rd})
        2'b10:   fifo_cnt <= fifo_cnt + 10'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 10'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------- SPI byte engine (mode 0) ----------------
  logic          spi_start, spi_busy, spi_done, ck_q, init_done;
  logic [7:0]    spi_tx, tx_sr, spi_rx;
  logic [3:0]    edge_cnt;
  logic [HW-1:0] half_tmr, half_ld;

  assign half_ld = init_done ? HW'(1) : HW'(INIT_CK_DIV / 2 - 1);
  assign sd_ck   = ck_q;
  assign sd_mosi = tx_sr[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_busy <= 1'b0;
      spi_done <= 1'b0;
      ck_q     <= 1'b0;
      tx_sr    <= 8'hFF;
      spi_rx   <= '0;
      edge_cnt <= '0;
      half_tmr <= '0;
    end else begin
      spi_done <= 1'b0;
      if (spi_start) begin
        spi_busy <= 1'b1;
        tx_sr    <= spi_tx;
        half_tmr <= half_ld;
        edge_cnt <= '0;
      end else if (spi_busy) begin
        if (half_tmr != '0) begin
          half_tmr <= half_tmr - 1'b1;
        end else begin
          half_tmr <= half_ld;
          ck_q     <= ~ck_q;
          edge_cnt <= edge_cnt + 4'd1;
          if (!ck_q) spi_rx <= {spi_rx[6:0], sd_miso};
          else       tx_sr  <= {tx_sr[6:0], 1'b1};
          if (edge_cnt == 4'd15) begin
            spi_busy <= 1'b0;
            spi_done <= 1'b1;
          end
        end
      end
    end
  end

  // ---------------- control FSM ----------------
  state_e      state, state_nxt;
  cmd_e        cmd_sel, cmd_nxt;
  logic [9:0]  byte_cnt, cnt_nxt;
  logic [7:0]  r1, r1_nxt;
  logic        r1_ok, r1_ok_nxt, wr_ok, wr_ok_nxt, init_nxt, blk_go;
  logic [31:0] sect_addr, addr_nxt;

  function automatic logic [7:0] frame_byte(input cmd_e c, input logic [9:0] i,
                                            input logic [31:0] a);
    logic [47:0] f;
    case (c)
      C_CMD0:   f = 48'h40_0000_0000_95;
      C_CMD8:   f = 48'h48_0000_01AA_87;
      C_CMD55:  f = 48'h77_0000_0000_65;
      C_ACMD41: f = 48'h69_4000_0000_77;
      default:  f = {8'h58, a, 8'hFF};
    endcase
    return f[8 * (5 - int'(i[2:0])) +: 8];
  endfunction

  assign blk_go = (fifo_cnt == 10'd512) || (!fifo_empty && idle_done);

  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd_sel;
    cnt_nxt   = byte_cnt;
    r1_nxt    = r1;
    r1_ok_nxt = r1_ok;
    wr_ok_nxt = wr_ok;
    addr_nxt  = sect_addr;
    init_nxt  = init_done;
    spi_tx    = 8'hFF;
    spi_start = (state != S_READY) && !spi_busy && !spi_done;
    fifo_rd   = 1'b0;
    case (state)
      S_PWRUP: if (spi_done) begin
        if (byte_cnt == 10'd9) begin
          state_nxt = S_CMD_FF;
          cmd_nxt   = C_CMD0;
          cnt_nxt   = '0;
        end else cnt_nxt = byte_cnt + 10'd1;
      end
      S_CMD_FF: if (spi_done) begin
        state_nxt = S_CMD_TX;
        cnt_nxt   = '0;
      end
      S_CMD_TX: begin
        spi_tx = frame_byte(cmd_sel, byte_cnt, sect_addr);
        if (spi_done) begin
          if (byte_cnt == 10'd5) begin
            state_nxt = S_CMD_RESP;
            cnt_nxt   = '0;
          end else cnt_nxt = byte_cnt + 10'd1;
        end
      end
      S_CMD_RESP: if (spi_done) begin
        if (!spi_rx[7]) begin
          r1_nxt    = spi_rx;
          r1_ok_nxt = 1'b1;
          cnt_nxt   = '0;
          if (cmd_sel == C_CMD8)                           state_nxt = S_CMD_TRAIL;
          else if (cmd_sel == C_CMD24 && spi_rx == 8'h00) state_nxt = S_WR_GAP;
          else                                             state_nxt = S_CMD_END;
        end else if (byte_cnt == 10'd7) begin
          r1_ok_nxt = 1'b0;
          state_nxt = S_CMD_END;
        end else cnt_nxt = byte_cnt + 10'd1;
      end
      S_CMD_TRAIL: if (spi_done) begin
        if (byte_cnt == 10'd3) state_nxt = S_CMD_END;
        else                   cnt_nxt   = byte_cnt + 10'd1;
      end
      S_CMD_END: if (spi_done) begin
        // no valid R1 leaves cmd_sel alone, so the same command is retried
        cnt_nxt   = '0;
        state_nxt = S_CMD_FF;
        if (r1_ok) begin
          case (cmd_sel)
            C_CMD0:   if (r1 == 8'h01) cmd_nxt = C_CMD8;
            C_CMD8:   cmd_nxt = C_CMD55;
            C_CMD55:  cmd_nxt = C_ACMD41;
            C_ACMD41: if (r1 == 8'h00) begin
              state_nxt = S_READY;
              init_nxt  = 1'b1;
            end else cmd_nxt = C_CMD55;
            default: begin
              state_nxt = S_READY;
              if (wr_ok) addr_nxt = sect_addr + 32'd1;
            end
          endcase
        end
      end
      S_READY: if (blk_go) begin
        state_nxt = S_CMD_FF;
        cmd_nxt   = C_CMD24;
        wr_ok_nxt = 1'b0;
        cnt_nxt   = '0;
      end
      S_WR_GAP: if (spi_done) state_nxt = S_WR_TOKEN;
      S_WR_TOKEN: begin
        spi_tx = 8'hFE;
        if (spi_done) begin
          state_nxt = S_WR_DATA;
          cnt_nxt   = '0;
        end
      end
      S_WR_DATA: begin
        spi_tx  = fifo_empty ? 8'h00 : fifo_dout;
        fifo_rd = spi_start && !fifo_empty;
        if (spi_done) begin
          cnt_nxt = byte_cnt + 10'd1;
          if (byte_cnt == 10'd511) begin
            state_nxt = S_WR_CRC;
            cnt_nxt   = '0;
          end
        end
      end
      S_WR_CRC: if (spi_done) begin
        if (byte_cnt == 10'd1) state_nxt = S_WR_RESP;
        else                   cnt_nxt   = byte_cnt + 10'd1;
      end
      S_WR_RESP: if (spi_done) begin
        if (spi_rx[4:0] == 5'h05) begin
          wr_ok_nxt = 1'b1;
          state_nxt = S_WR_BUSY;
        end else state_nxt = S_CMD_END;
      end
      S_WR_BUSY: if (spi_done && spi_rx == 8'hFF) state_nxt = S_CMD_END;
      default: state_nxt = S_PWRUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_PWRUP;
      cmd_sel   <= C_CMD0;
      byte_cnt  <= '0;
      r1        <= 8'hFF;
      r1_ok     <= 1'b0;
      wr_ok     <= 1'b0;
      sect_addr <= '0;
      init_done <= 1'b0;
      sd_csn    <= 1'b1;
    end else begin
      state     <= state_nxt;
      cmd_sel   <= cmd_nxt;
      byte_cnt  <= cnt_nxt;
      r1        <= r1_nxt;
      r1_ok     <= r1_ok_nxt;
      wr_ok     <= wr_ok_nxt;
      sect_addr <= addr_nxt;
      init_done <= init_nxt;
      sd_csn    <= (state_nxt == S_PWRUP) || (state_nxt == S_READY) ||
                   (state_nxt == S_CMD_END);
    end
  end

endmodule

// File: tb/tb_top.sv
// Directed bench for the UART-to-SD bridge: a reactive SD card model answers commands and
// captures blocks; UART bytes are driven at a scaled-down bit rate.
module tb_top;
  localparam int BIT_CLKS = 16;

  logic clk = 1'b0;
  logic rst_n, mosi, sd_ck, sd_mosi, sd_miso, sd_csn;

  top #(.CLK_HZ(50_000_000), .BAUD(3_125_000), .IDLE_BITS(10), .INIT_CK_DIV(8)) dut (
    .clk(clk), .rst_n(rst_n), .mosi(mosi), .sd_ck(sd_ck), .sd_mosi(sd_mosi),
    .sd_miso(sd_miso), .sd_csn(sd_csn)
  );

  always #10 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- SD card model ----------------
  logic [7:0]  c_sr = 8'hFF;
  logic [7:0]  c_out = 8'hFF;
  int          c_bits = 0, c_mode = 0, c_fn = 0, c_dn = 0, acmd_n = 0;
  logic [47:0] c_frame = '0;
  logic [31:0] c_addr = '0;
  logic [7:0]  oq[$];
  logic [47:0] cmd_log[$];
  logic [7:0]  blk_data [512];
  logic [31:0] blk_addr = '0;
  logic [15:0] blk_crc = '0;
  int          blk_cnt = 0, pwr_clks = 0;
  bit          seen_cs = 1'b0;
  logic [7:0]  resp_code = 8'h05;

  assign sd_miso = c_out[7];

  always @(posedge sd_ck or negedge rst_n) begin
    if (!rst_n) begin
      c_bits = 0; c_mode = 0; c_fn = 0; c_dn = 0; acmd_n = 0; pwr_clks = 0; seen_cs = 1'b0;
    end else begin
      if (!sd_csn) seen_cs = 1'b1;
      else if (!seen_cs) pwr_clks++;
      c_sr = {c_sr[6:0], sd_mosi};
      c_bits++;
      if (c_bits == 8) begin
        c_bits = 0;
        case (c_mode)
          0: if (!sd_csn) begin
            if (c_fn == 0) begin
              if (c_sr[7:6] == 2'b01) begin c_frame = {40'h0, c_sr}; c_fn = 1; end
            end else begin
              c_frame = {c_frame[39:0], c_sr};
              c_fn++;
              if (c_fn == 6) begin
                c_fn = 0;
                cmd_log.push_back(c_frame);
                case (c_frame[45:40])
                  6'd0:  oq.push_back(8'h01);
                  6'd8:  begin
                    oq.push_back(8'h01); oq.push_back(8'h00); oq.push_back(8'h00);
                    oq.push_back(8'h01); oq.push_back(8'hAA);
                  end
                  6'd55: oq.push_back(8'h01);
                  6'd41: begin oq.push_back(acmd_n == 0 ? 8'h01 : 8'h00); acmd_n++; end
                  6'd24: begin oq.push_back(8'h00); c_addr = c_frame[39:8]; c_mode = 1; end
                  default: oq.push_back(8'h04);
                endcase
              end
            end
          end
          1: if (c_sr == 8'hFE) begin c_mode = 2; c_dn = 0; end
          2: begin
            blk_data[c_dn] = c_sr;
            c_dn++;
            if (c_dn == 512) begin c_mode = 3; c_dn = 0; end
          end
          default: begin
            blk_crc = {blk_crc[7:0], c_sr};
            c_dn++;
            if (c_dn == 2) begin
              blk_addr = c_addr;
              blk_cnt++;
              oq.push_back(resp_code);
              if (resp_code[4:0] == 5'h05) begin oq.push_back(8'h00); oq.push_back(8'h00); end
              c_mode = 0;
            end
          end
        endcase
      end
    end
  end

  always @(negedge sd_ck or negedge rst_n) begin
    if (!rst_n) begin
      c_out = 8'hFF;
      oq.delete();
    end else if (c_bits == 0) begin
      c_out = (oq.size() != 0) ? oq.pop_front() : 8'hFF;
    end else begin
      c_out = {c_out[6:0], 1'b1};
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic uart_tx(input logic [7:0] b, input logic stop_bit);
    mosi = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      mosi = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    mosi = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
    mosi = 1'b1;
  endtask

  function automatic int nz_from(input int k);
    int n = 0;
    for (int i = k; i < 512; i++) if (blk_data[i] != 8'h00) n++;
    return n;
  endfunction

  task automatic wait_init(input int base);
    logic [47:0] exp_f [6];
    int n = 0;
    exp_f = '{48'h40_0000_0000_95, 48'h48_0000_01AA_87, 48'h77_0000_0000_65,
              48'h69_4000_0000_77, 48'h77_0000_0000_65, 48'h69_4000_0000_77};
    while (cmd_log.size() < base + 6 && n < 20000) begin @(negedge clk); n++; end
    chk("init_cmds", 64'(cmd_log.size()), 64'(base + 6));
    repeat (200) @(negedge clk);
    chk("init_csn", 64'(sd_csn), 64'd1);
    chk("pwrup_clks", 64'(pwr_clks), 64'd80);
    for (int i = 0; i < 6; i++) chk("init_frame", 64'(cmd_log[base + i]), 64'(exp_f[i]));
  endtask

  task automatic wait_blk(input int cnt);
    int n = 0;
    while (blk_cnt < cnt && n < 30000) begin @(negedge clk); n++; end
    chk("blk_done", 64'(blk_cnt), 64'(cnt));
    repeat (300) @(negedge clk);
  endtask

  initial begin
    #4ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    mosi  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_csn", 64'(sd_csn), 64'd1);
    chk("rst_ck", 64'(sd_ck), 64'd0);
    chk("rst_mosi", 64'(sd_mosi), 64'd1);
    rst_n = 1'b1;
    wait_init(0);

    uart_tx(8'hA5, 1'b1);
    repeat (100) @(negedge clk);
    chk("idle_hold", 64'(cmd_log.size()), 64'd6);
    wait_blk(1);
    chk("a5_cmd24", 64'(cmd_log[6]), 64'h58_0000_0000_FF);
    chk("a5_addr", 64'(blk_addr), 64'd0);
    chk("a5_d0", 64'(blk_data[0]), 64'hA5);
    chk("a5_pad", 64'(nz_from(1)), 64'd0);
    chk("a5_crc", 64'(blk_crc), 64'hFFFF);

    uart_tx(8'h31, 1'b1);
    uart_tx(8'h32, 1'b1);
    uart_tx(8'h33, 1'b1);
    wait_blk(2);
    chk("b3_cmd24", 64'(cmd_log[7]), 64'h58_0000_0001_FF);
    chk("b3_addr", 64'(blk_addr), 64'd1);
    chk("b3_d0", 64'(blk_data[0]), 64'h31);
    chk("b3_d1", 64'(blk_data[1]), 64'h32);
    chk("b3_d2", 64'(blk_data[2]), 64'h33);
    chk("b3_pad", 64'(nz_from(3)), 64'd0);

    uart_tx(8'h77, 1'b0);
    repeat (400) @(negedge clk);
    chk("ferr_cmds", 64'(cmd_log.size()), 64'd8);
    chk("ferr_blks", 64'(blk_cnt), 64'd2);

    resp_code = 8'h0B;
    uart_tx(8'h44, 1'b1);
    wait_blk(3);
    chk("rej_addr", 64'(blk_addr), 64'd2);
    chk("rej_d0", 64'(blk_data[0]), 64'h44);
    resp_code = 8'h05;

    uart_tx(8'h55, 1'b1);
    n = 0;
    while (!(c_mode == 2 && c_dn >= 100) && n < 30000) begin @(negedge clk); n++; end
    chk("reach_data", 64'(c_mode == 2 && c_dn >= 100), 64'd1);
    chk("reuse_cmd24", 64'(cmd_log[9]), 64'h58_0000_0002_FF);
    chk("mid_csn", 64'(sd_csn), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("async_csn", 64'(sd_csn), 64'd1);
    chk("async_ck", 64'(sd_ck), 64'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    wait_init(10);
    repeat (500) @(negedge clk);
    chk("post_rst_idle", 64'(cmd_log.size()), 64'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, UART bit rate; bit period BIT_CLKS = CLK_HZ/BAUD rounded to nearest (5208).
REQ-003 Parameter IDLE_BITS, default 10, UART idle time in bit periods that triggers a partial-block flush.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 clk  input  1  single system clock, rising edge.
REQ-006 mosi  input  1  UART RX line from the PC, idle high, 8N1, LSB first.
REQ-007 sd_ck  output  1  SPI clock to the SD card, SPI mode 0.
REQ-008 sd_mosi  output  1  SPI data to the card.
REQ-009 sd_miso  input  1  SPI data from the card.
REQ-010 sd_csn  output  1  SD chip select, active low.

Function
REQ-011 UART RX shall pass mosi through a 2-FF synchronizer, detect start on a 1->0 edge, re-check low at half-bit, then sample 8 data bits at mid-bit, LSB first.
REQ-012 Stop bit shall be sampled at mid-bit; if 0 the byte is discarded (framing error), otherwise it is written to the FIFO one cycle after the stop sample.
REQ-013 FIFO shall hold 512 bytes with a 10-bit count; a write when full is dropped; a simultaneous write and read leaves count unchanged; pointers wrap modulo 512.
REQ-014 SPI: sd_mosi changes on sd_ck falling edge, sd_miso sampled on rising edge, MSB first; sd_ck = clk/128 during init, clk/4 after init completes.
REQ-015 Init FSM: PWRUP (sd_csn=1, sd_mosi=1, 80 sd_ck cycles) -> CMD0 -> CMD8 -> CMD55 -> ACMD41 -> READY.
REQ-016 Each command: CS low, one 0xFF byte, 6 command bytes, then read bytes until bit7=0 (max 8, else retry same command); after the response (plus any trailing bytes) CS high and 8 dummy clocks.
REQ-017 Command frames: CMD0 = 40 00 00 00 00 95; CMD8 = 48 00 00 01 AA 87 (R7: 4 extra bytes read and ignored); CMD55 = 77 00 00 00 00 65; ACMD41 = 69 40 00 00 00 77.
REQ-018 CMD0 R1 must be 0x01, else retry CMD0; ACMD41 R1 = 0x00 -> READY, R1 = 0x01 -> repeat CMD55/ACMD41.
REQ-019 In READY, a block write shall start when FIFO count reaches 512, or count > 0 and the RX line has been idle for IDLE_BITS bit periods since the last stop bit.
REQ-020 Block write: CMD24 = 58 + 32-bit sector address (block addressing) + FF; R1 must be 0x00, else abort to READY without consuming data.
REQ-021 Then one 0xFF byte, token 0xFE, 512 data bytes popped from the FIFO (0x00 padding once empty), CRC 0xFF 0xFF.
REQ-022 Data response byte: (resp & 0x1F) == 0x05 means accepted; then clock 0xFF until sd_miso byte reads 0xFF (busy over), CS high, 8 dummy clocks, sector address +1, back to READY.
REQ-023 A rejected data response shall return to READY without incrementing the address; popped bytes are lost.
REQ-024 UART reception and FIFO writes shall continue during SD init and block writes.
REQ-025 Sector address starts at 0 and wraps at 2^32.

Reset
REQ-026 On rst_n low, immediately: sd_csn=1, sd_ck=0, sd_mosi=1, FIFO empty, sector address 0, UART RX idle, FSM in PWRUP.
REQ-027 Reset asserted mid-command or mid-block shall abort the transfer; after release the full init sequence restarts and FIFO contents are lost.

Verification
REQ-028 Release reset, sd_miso model idle 0xFF then R1 0x01/0x00 -> 80 clocks with CS high, then CMD0, CMD8, CMD55, ACMD41 frames byte-exact, then READY.
REQ-029 After init, UART byte 0xA5 at 104 us/bit, then idle 1.04 ms -> CMD24 address 0, token 0xFE, data A5 followed by 511 x 00, FF FF.
REQ-030 Send 0x31, 0x32, 0x33 back to back -> one block with data 31 32 33 then padding; next flush uses sector address 1.
REQ-031 Byte with stop bit forced 0 -> no FIFO write, no block write triggered.
REQ-032 Card returns data response 0x0B -> no address increment; next flush reuses the same sector address.
REQ-033 Assert rst_n low during block data phase -> sd_csn goes 1 asynchronously; after release, init sequence repeats from PWRUP.
